mem_access_unit: RTL and testbench

Byte-addressed load/store initiator between the MIPS32 execute stage and the word-addressed `data_mem` responder. It accepts one byte, halfword or word access at a time and converts byte addresses to word indices. Sub-word stores run as read-modify-write sequences. Loads are returned sign- or zero-extended.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator in front of a word-addressed data memory.
// Optional misalignment trap: define MEM_ACCESS_MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_read_address,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic        sig_mem_read,
    output logic        sig_mem_write,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_t      state_q, state_d;
    logic        write_q;
    logic        signed_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [1:0]  lo_q;
    logic [31:0] idx_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;

    logic        accept;
    logic        req_err;
    logic [31:0] req_idx;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] merged;

    assign accept  = req_valid && (state_q == IDLE);
    assign req_idx = {2'b00, req_addr[31:2]};

    // Classify the incoming request as an error before any memory access.
    always_comb begin
        req_err = (req_size == 2'b11) || (req_idx >= MEM_WORDS);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        if (req_size == SZ_HALF && req_addr[0])
            req_err = 1'b1;
        if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_err = 1'b1;
`endif
    end

    // Next-state logic for the access sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (!req_write)
                        state_d = READ;
                    else if (req_size == SZ_WORD)
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    state_d = write_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset aborts any in-flight access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Request fields are held for the whole access; memory word captured leaving READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            err_q    <= 1'b0;
            size_q   <= 2'b00;
            lo_q     <= 2'b00;
            idx_q    <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
        end else begin
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                err_q    <= req_err;
                size_q   <= req_size;
                lo_q     <= req_addr[1:0];
                idx_q    <= req_idx;
                wdata_q  <= req_wdata;
            end
            if (state_q == READ)
                word_q <= mem_read_data;
        end
    end

    // Lane extraction and extension for loads (little-endian lanes).
    always_comb begin
        unique case (lo_q)
            2'd0:    ld_byte = word_q[7:0];
            2'd1:    ld_byte = word_q[15:8];
            2'd2:    ld_byte = word_q[23:16];
            default: ld_byte = word_q[31:24];
        endcase
        ld_half = lo_q[1] ? word_q[31:16] : word_q[15:0];
        unique case (size_q)
            SZ_BYTE: ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
            default: ld_data = word_q;
        endcase
    end

    // Read-modify-write merge: only the target lane(s) change.
    always_comb begin
        merged = word_q;
        if (size_q == SZ_BYTE) begin
            unique case (lo_q)
                2'd0:    merged[7:0]   = wdata_q[7:0];
                2'd1:    merged[15:8]  = wdata_q[7:0];
                2'd2:    merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (lo_q[1]) begin
            merged[31:16] = wdata_q[15:0];
        end else begin
            merged[15:0] = wdata_q[15:0];
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = (state_q == RESP && !err_q && !write_q) ? ld_data : 32'h0;

    assign sig_mem_read     = (state_q == READ);
    assign mem_read_address = (state_q == READ) ? idx_q : 32'hFFFF_FFFF;

    assign sig_mem_write     = (state_q == WRITE);
    assign mem_write_address = (state_q == WRITE) ? idx_q : 32'h0;
    assign mem_write_data    = (state_q != WRITE) ? 32'h0 :
                               (size_q == SZ_WORD) ? wdata_q : merged;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a 256-word memory model.
// Expected values are hand-computed little-endian lane results.
module tb_mem_access_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_read_address;
    logic [31:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic        sig_mem_read;
    logic        sig_mem_write;
    logic [31:0] mem_read_data;

    logic [31:0] mem [256];

    int checks;
    int failures;

    mem_access_unit #(.MEM_WORDS(256)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_write        (req_write),
        .req_size         (req_size),
        .req_signed       (req_signed),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_err         (resp_err),
        .mem_read_address (mem_read_address),
        .mem_write_address(mem_write_address),
        .mem_write_data   (mem_write_data),
        .sig_mem_read     (sig_mem_read),
        .sig_mem_write    (sig_mem_write),
        .mem_read_data    (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational read, write on the edge ending WRITE.
    always_comb begin
        mem_read_data = 32'h0;
        if (mem_read_address < 32'd256)
            mem_read_data = mem[mem_read_address[7:0]];
    end

    always @(posedge clk) begin
        if (sig_mem_write && mem_write_address < 32'd256)
            mem[mem_write_address[7:0]] <= mem_write_data;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, return response fields, latency (edges after accept)
    // and whether a memory read strobe was seen while waiting.
    task automatic xfer(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic err,
                        output int lat, output logic sawrd, output logic rdy_after);
        @(posedge clk);
        #1;
        req_valid  = 1'b1;
        req_write  = w;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat   = 0;
        rd    = 32'h0;
        err   = 1'b0;
        sawrd = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (sig_mem_read)
                sawrd = 1'b1;
            if (resp_valid) begin
                lat = i;
                rd  = resp_rdata;
                err = resp_err;
                break;
            end
        end
        @(posedge clk);
        #1;
        rdy_after = req_ready;
    endtask

    logic [31:0] rd;
    logic        err;
    int          lat;
    logic        sawrd;
    logic        rdy;

    initial begin
        checks     = 0;
        failures   = 0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        #2;
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_rvalid", {31'h0, resp_valid}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", {31'h0, resp_err}, 32'h0);
        chk("rst_rd", {31'h0, sig_mem_read}, 32'h0);
        chk("rst_wr", {31'h0, sig_mem_write}, 32'h0);
        chk("rst_raddr", mem_read_address, 32'hFFFF_FFFF);
        chk("rst_waddr", mem_write_address, 32'h0);
        chk("rst_wdata", mem_write_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then word load at 0x10.
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, rd, err, lat, sawrd, rdy);
        chk("wst_lat", lat, 32'd2);
        chk("wst_err", {31'h0, err}, 32'h0);
        chk("wst_mem", mem[4], 32'hDEADBEEF);
        chk("wst_rdy", {31'h0, rdy}, 32'h1);
        xfer(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, err, lat, sawrd, rdy);
        chk("wld_lat", lat, 32'd2);
        chk("wld_data", rd, 32'hDEADBEEF);
        chk("wld_err", {31'h0, err}, 32'h0);

        // Byte store into lane 2 of 0x11223344.
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, rd, err, lat, sawrd, rdy);
        xfer(1'b1, 2'b00, 1'b0, 32'h12, 32'hFFFFFFAB, rd, err, lat, sawrd, rdy);
        chk("bst_lat", lat, 32'd3);
        chk("bst_rd", {31'h0, sawrd}, 32'h1);
        chk("bst_mem", mem[4], 32'h11AB3344);
        chk("bst_rdata", rd, 32'h0);

        // Half store into the low half.
        xfer(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234ABCD, rd, err, lat, sawrd, rdy);
        chk("hst_lat", lat, 32'd3);
        chk("hst_mem", mem[4], 32'h11ABABCD);

        // Extension cases on 0x80FF7F01.
        xfer(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, rd, err, lat, sawrd, rdy);
        xfer(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, rd, err, lat, sawrd, rdy);
        chk("lbs_13", rd, 32'hFFFFFF80);
        xfer(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, rd, err, lat, sawrd, rdy);
        chk("lbu_13", rd, 32'h00000080);
        xfer(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, rd, err, lat, sawrd, rdy);
        chk("lhu_12", rd, 32'h000080FF);
        xfer(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, rd, err, lat, sawrd, rdy);
        chk("lhs_12", rd, 32'hFFFF80FF);
        xfer(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, rd, err, lat, sawrd, rdy);
        chk("lhs_10", rd, 32'h00007F01);
        chk("lhs_lat", lat, 32'd2);
        xfer(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, rd, err, lat, sawrd, rdy);
        chk("lbs_11", rd, 32'h0000007F);

        // Out-of-range word index.
        xfer(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, rd, err, lat, sawrd, rdy);
        chk("oor_lat", lat, 32'd1);
        chk("oor_err", {31'h0, err}, 32'h1);
        chk("oor_rd", {31'h0, sawrd}, 32'h0);
        chk("oor_rdata", rd, 32'h0);

        // Last valid index still works.
        xfer(1'b1, 2'b10, 1'b0, 32'h3FC, 32'hCAFEF00D, rd, err, lat, sawrd, rdy);
        chk("top_err", {31'h0, err}, 32'h0);
        chk("top_mem", mem[255], 32'hCAFEF00D);

        // Illegal size.
        xfer(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, err, lat, sawrd, rdy);
        chk("sz3_lat", lat, 32'd1);
        chk("sz3_err", {31'h0, err}, 32'h1);
        xfer(1'b1, 2'b11, 1'b0, 32'h10, 32'h55555555, rd, err, lat, sawrd, rdy);
        chk("sz3_mem", mem[4], 32'h80FF7F01);

        // Misaligned half load.
        xfer(1'b0, 2'b01, 1'b0, 32'h11, 32'h0, rd, err, lat, sawrd, rdy);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        chk("mis_lat", lat, 32'd1);
        chk("mis_err", {31'h0, err}, 32'h1);
        chk("mis_rd", {31'h0, sawrd}, 32'h0);
`else
        chk("mis_lat", lat, 32'd2);
        chk("mis_err", {31'h0, err}, 32'h0);
        chk("mis_data", rd, 32'h00007F01);
`endif

        // Reset during WRITE of a word store to 0x20.
        xfer(1'b1, 2'b10, 1'b0, 32'h20, 32'h5, rd, err, lat, sawrd, rdy);
        chk("pre_mem", mem[8], 32'h5);
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_addr  = 32'h20;
        req_wdata = 32'h99999999;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("abort_wr_on", {31'h0, sig_mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("abort_wr_off", {31'h0, sig_mem_write}, 32'h0);
        chk("abort_waddr", mem_write_address, 32'h0);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        chk("abort_mem", mem[8], 32'h5);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (resp_valid)
                lat = i;
        end
        chk("abort_noresp", lat, 32'd0);
        chk("abort_rdy", {31'h0, req_ready}, 32'h1);
        chk("abort_mem2", mem[8], 32'h5);

        // First request right after reset release.
        xfer(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, rd, err, lat, sawrd, rdy);
        chk("post_data", rd, 32'h5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
